// File: rtl/alu_arbiter_pkg.sv
// alu_pkg: RV32I ALU operation codes {funct7[5], funct3} and the legal-code check
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b1000,
      OP_SLL  = 4'b0001,
      OP_SLT  = 4'b0010,
      OP_SLTU = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SRL  = 4'b0101,
      OP_SRA  = 4'b1101,
      OP_OR   = 4'b0110,
      OP_AND  = 4'b0111
   } alu_op_e;

   function automatic logic is_legal_op(input logic [3:0] code);
      return code inside {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
                          OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND};
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two requester channels and one response channel around the shared ALU
interface alu_arbiter_if;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [3:0]  req0_operation, req1_operation;
   logic        resp_valid, resp_ready, resp_id, resp_illegal;
   logic [31:0] resp_result;

   modport slave (
      input  req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
             req0_operation, req1_operation, resp_ready,
      output req0_ready, req1_ready, resp_valid, resp_id, resp_result, resp_illegal
   );

   modport master (
      output req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
             req0_operation, req1_operation, resp_ready,
      input  req0_ready, req1_ready, resp_valid, resp_id, resp_result, resp_illegal
   );
endinterface

// File: rtl/alu_arbiter_alu.sv
// alu: combinational RV32I integer ALU; unknown codes yield zero
module alu
   import alu_pkg::*;
(
   input  logic [31:0] operand1,
   input  logic [31:0] operand2,
   input  logic [3:0]  operation,
   output logic [31:0] result
);

   // shifts use only the low five bits of operand2
   always_comb begin
      result = '0;
      case (operation)
         OP_ADD:  result = operand1 + operand2;
         OP_SUB:  result = operand1 - operand2;
         OP_SLL:  result = operand1 << operand2[4:0];
         OP_SLT:  result = {31'd0, $signed(operand1) < $signed(operand2)};
         OP_SLTU: result = {31'd0, operand1 < operand2};
         OP_XOR:  result = operand1 ^ operand2;
         OP_SRL:  result = operand1 >> operand2[4:0];
         OP_SRA:  result = $unsigned($signed(operand1) >>> operand2[4:0]);
         OP_OR:   result = operand1 | operand2;
         OP_AND:  result = operand1 & operand2;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter feeding one registered ALU slot
module alu_arbiter
   import alu_pkg::*;
#(
   parameter bit RR_ENABLE = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_arbiter_if.slave   bus
);

   logic        slot_free, grant1, accept;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_id_q, resp_id_d;
   logic        last_grant_q, last_grant_d;
   logic [31:0] op1_q, op1_d, op2_q, op2_d;
   logic [3:0]  code_q, code_d;
   logic [31:0] alu_result;

   // pick a winner; only it sees ready, and only when the slot can take a new operation
   always_comb begin
      slot_free      = !resp_valid_q || bus.resp_ready;
      grant1         = bus.req1_valid && (!bus.req0_valid || (RR_ENABLE && !last_grant_q));
      bus.req0_ready = rst_n && slot_free && bus.req0_valid && !grant1;
      bus.req1_ready = rst_n && slot_free && grant1;
      accept         = bus.req0_ready || bus.req1_ready;
   end

   // load the winner's operands on acceptance, otherwise hold; drop valid once consumed
   always_comb begin
      resp_valid_d = accept || (resp_valid_q && !bus.resp_ready);
      resp_id_d    = accept ? grant1 : resp_id_q;
      last_grant_d = accept ? grant1 : last_grant_q;
      op1_d        = accept ? (grant1 ? bus.req1_op1 : bus.req0_op1) : op1_q;
      op2_d        = accept ? (grant1 ? bus.req1_op2 : bus.req0_op2) : op2_q;
      code_d       = accept ? (grant1 ? bus.req1_operation : bus.req0_operation) : code_q;
   end

   // slot registers; cleared operands (ADD 0+0) make the reset result read as zero
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         last_grant_q <= 1'b1;
         op1_q        <= '0;
         op2_q        <= '0;
         code_q       <= OP_ADD;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         last_grant_q <= last_grant_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         code_q       <= code_d;
      end
   end

   alu alu (
      .operand1  (op1_q),
      .operand2  (op2_q),
      .operation (code_q),
      .result    (alu_result)
   );

   // response is derived from the held operation, so it stays stable while stalled
   always_comb begin
      bus.resp_valid   = resp_valid_q;
      bus.resp_id      = resp_id_q;
      bus.resp_illegal = !is_legal_op(code_q);
      bus.resp_result  = bus.resp_illegal ? '0 : alu_result;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors, corner sequences and a random run against a reference model
module tb_alu_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if bus ();
   alu_arbiter_if bus_fp ();

   alu_arbiter #(.RR_ENABLE(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   alu_arbiter #(.RR_ENABLE(1'b0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

   assign bus_fp.req0_valid     = bus.req0_valid;
   assign bus_fp.req1_valid     = bus.req1_valid;
   assign bus_fp.req0_op1       = bus.req0_op1;
   assign bus_fp.req0_op2       = bus.req0_op2;
   assign bus_fp.req1_op1       = bus.req1_op1;
   assign bus_fp.req1_op2       = bus.req1_op2;
   assign bus_fp.req0_operation = bus.req0_operation;
   assign bus_fp.req1_operation = bus.req1_operation;
   assign bus_fp.resp_ready     = bus.resp_ready;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        id;
      logic [3:0]  code;
      logic [31:0] a, b, res;
      logic        ill;
   } vec_t;

   vec_t vecs[13];

   logic        m_valid[2], m_id[2], m_ill[2], m_last[2];
   logic [31:0] m_res[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic ref_illegal(input logic [3:0] c);
      return !(c inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                         4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111});
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      int sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % 32);
      case (c)
         4'b0000: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
         4'b1000: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
         4'b0001: return 32'((longint'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
         4'b0010: return (sa < sb) ? 32'd1 : 32'd0;
         4'b0011: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
         4'b0100: return a ^ b;
         4'b0101: return 32'(longint'(a) / (64'd1 << sh));
         4'b1101: return 32'((sa - ((sa % (64'd1 << sh) + (64'd1 << sh)) % (64'd1 << sh))) / (64'd1 << sh));
         4'b0110: return a | b;
         4'b0111: return a & b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic idle();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic drive(input logic id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_operation = c; bus.req1_op1 = a; bus.req1_op2 = b;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_operation = c; bus.req0_op1 = a; bus.req0_op2 = b;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      bus.resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic v0, v1, rdy, e0[2], e1[2];
      logic [31:0] a0, b0, a1, b1;
      logic [3:0] c0, c1, cw;
      string tag;

      vecs[0]  = '{1'b0, 4'b0000, 32'd5,        32'd7,        32'd12,       1'b0};
      vecs[1]  = '{1'b0, 4'b1101, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0};
      vecs[2]  = '{1'b1, 4'b0010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
      vecs[3]  = '{1'b0, 4'b0011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
      vecs[4]  = '{1'b1, 4'b1000, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
      vecs[5]  = '{1'b0, 4'b0000, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0};
      vecs[6]  = '{1'b1, 4'b0001, 32'd1,        32'h00000021, 32'd2,        1'b0};
      vecs[7]  = '{1'b0, 4'b0101, 32'h80000000, 32'd4,        32'h08000000, 1'b0};
      vecs[8]  = '{1'b1, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
      vecs[9]  = '{1'b0, 4'b0110, 32'h0F000000, 32'h000000F0, 32'h0F0000F0, 1'b0};
      vecs[10] = '{1'b1, 4'b0111, 32'h12345678, 32'h0000FFFF, 32'h00005678, 1'b0};
      vecs[11] = '{1'b1, 4'b1001, 32'd1,        32'd2,        32'd0,        1'b1};
      vecs[12] = '{1'b0, 4'b1111, 32'd9,        32'd9,        32'd0,        1'b1};

      bus.req0_op1 = '0; bus.req0_op2 = '0; bus.req0_operation = '0;
      bus.req1_op1 = '0; bus.req1_op2 = '0; bus.req1_operation = '0;
      do_reset();

      @(negedge clk);
      chk("reset resp_valid", bus.resp_valid, 0);
      chk("reset resp_id", bus.resp_id, 0);
      chk("reset resp_result", bus.resp_result, 0);
      chk("reset resp_illegal", bus.resp_illegal, 0);
      @(posedge clk); #1;

      // single-operation vectors
      foreach (vecs[i]) begin
         bus.resp_ready = 1'b1;
         drive(vecs[i].id, vecs[i].code, vecs[i].a, vecs[i].b);
         @(negedge clk);
         rdy = vecs[i].id ? bus.req1_ready : bus.req0_ready;
         chk($sformatf("vec%0d ready", i), rdy, 1);
         @(posedge clk); #1;
         idle();
         @(negedge clk);
         chk($sformatf("vec%0d resp_valid", i), bus.resp_valid, 1);
         chk($sformatf("vec%0d resp_id", i), bus.resp_id, vecs[i].id);
         chk($sformatf("vec%0d resp_result", i), bus.resp_result, vecs[i].res);
         chk($sformatf("vec%0d resp_illegal", i), bus.resp_illegal, vecs[i].ill);
         @(posedge clk); #1;
      end

      // both requesters valid every cycle: round-robin alternates, fixed priority keeps 0
      do_reset();
      bus.resp_ready = 1'b1;
      drive(1'b0, 4'b0000, 32'd1, 32'd1);
      drive(1'b1, 4'b0000, 32'd2, 32'd2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("rr grant%0d req0_ready", i), bus.req0_ready, (i % 2 == 0));
         chk($sformatf("rr grant%0d req1_ready", i), bus.req1_ready, (i % 2 == 1));
         chk($sformatf("fp grant%0d req0_ready", i), bus_fp.req0_ready, 1);
         chk($sformatf("fp grant%0d req1_ready", i), bus_fp.req1_ready, 0);
         if (i > 0) begin
            chk($sformatf("rr stream%0d resp_valid", i), bus.resp_valid, 1);
            chk($sformatf("rr stream%0d resp_id", i), bus.resp_id, (i - 1) % 2);
            chk($sformatf("rr stream%0d resp_result", i), bus.resp_result, ((i - 1) % 2) ? 32'd4 : 32'd2);
         end
         @(posedge clk); #1;
      end
      idle();
      @(negedge clk);
      chk("rr stream4 resp_id", bus.resp_id, 1);
      chk("rr stream4 resp_result", bus.resp_result, 4);
      @(posedge clk); #1;

      // stalled consumer: nothing accepted, result held; then accept on the consume cycle
      do_reset();
      bus.resp_ready = 1'b1;
      drive(1'b0, 4'b0000, 32'd10, 32'd20);
      @(posedge clk); #1;
      idle();
      bus.resp_ready = 1'b0;
      drive(1'b1, 4'b1000, 32'd50, 32'd8);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d req0_ready", i), bus.req0_ready, 0);
         chk($sformatf("stall%0d req1_ready", i), bus.req1_ready, 0);
         chk($sformatf("stall%0d resp_valid", i), bus.resp_valid, 1);
         chk($sformatf("stall%0d resp_result", i), bus.resp_result, 30);
         chk($sformatf("stall%0d resp_id", i), bus.resp_id, 0);
         @(posedge clk); #1;
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      chk("release req1_ready", bus.req1_ready, 1);
      @(posedge clk); #1;
      idle();
      bus.resp_ready = 1'b0;
      @(negedge clk);
      chk("release resp_valid", bus.resp_valid, 1);
      chk("release resp_id", bus.resp_id, 1);
      chk("release resp_result", bus.resp_result, 42);

      // reset while a result is held and unconsumed
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive(1'b0, 4'b0000, 32'd3, 32'd4);
      drive(1'b1, 4'b0000, 32'd5, 32'd6);
      @(negedge clk);
      chk("in-reset req0_ready", bus.req0_ready, 0);
      chk("in-reset req1_ready", bus.req1_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset resp_valid", bus.resp_valid, 0);
      chk("post-reset resp_result", bus.resp_result, 0);
      chk("post-reset req0_ready", bus.req0_ready, 1);
      chk("post-reset req1_ready", bus.req1_ready, 0);
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      chk("post-reset first resp_id", bus.resp_id, 0);
      chk("post-reset first resp_result", bus.resp_result, 7);
      @(posedge clk); #1;

      // random traffic against the model, both arbitration modes
      do_reset();
      for (int m = 0; m < 2; m++) begin
         m_valid[m] = 0; m_id[m] = 0; m_ill[m] = 0; m_last[m] = 1; m_res[m] = 0;
      end
      for (int t = 0; t < 800; t++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         v0 = $urandom_range(0, 2) != 0;
         v1 = $urandom_range(0, 2) != 0;
         a0 = $urandom; a1 = $urandom;
         b0 = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         b1 = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         c0 = 4'($urandom_range(0, 15)); c1 = 4'($urandom_range(0, 15));
         bus.resp_ready = $urandom_range(0, 3) != 0;
         idle();
         if (v0) drive(1'b0, c0, a0, b0);
         if (v1) drive(1'b1, c1, a1, b1);
         for (int m = 0; m < 2; m++) begin
            e0[m] = 0; e1[m] = 0;
            if (rst_n && (!m_valid[m] || bus.resp_ready)) begin
               if (v0 && v1) begin
                  e1[m] = (m == 0) ? !m_last[m] : 1'b0;
                  e0[m] = !e1[m];
               end else begin
                  e0[m] = v0;
                  e1[m] = v1;
               end
            end
         end
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            tag = (m == 0) ? "rnd rr" : "rnd fp";
            chk({tag, " req0_ready"}, (m == 0) ? bus.req0_ready : bus_fp.req0_ready, e0[m]);
            chk({tag, " req1_ready"}, (m == 0) ? bus.req1_ready : bus_fp.req1_ready, e1[m]);
            chk({tag, " resp_valid"}, (m == 0) ? bus.resp_valid : bus_fp.resp_valid, m_valid[m]);
            if (m_valid[m]) begin
               chk({tag, " resp_id"}, (m == 0) ? bus.resp_id : bus_fp.resp_id, m_id[m]);
               chk({tag, " resp_result"}, (m == 0) ? bus.resp_result : bus_fp.resp_result, m_res[m]);
               chk({tag, " resp_illegal"}, (m == 0) ? bus.resp_illegal : bus_fp.resp_illegal, m_ill[m]);
            end
         end
         @(posedge clk);
         for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
               m_valid[m] = 0; m_id[m] = 0; m_ill[m] = 0; m_last[m] = 1; m_res[m] = 0;
            end else if (e0[m] || e1[m]) begin
               cw = e1[m] ? c1 : c0;
               m_valid[m] = 1;
               m_id[m] = e1[m];
               m_last[m] = e1[m];
               m_ill[m] = ref_illegal(cw);
               m_res[m] = m_ill[m] ? 32'd0 : ref_alu(cw, e1[m] ? a1 : a0, e1[m] ? b1 : b0);
            end else if (bus.resp_ready) begin
               m_valid[m] = 0;
            end
         end
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_ENABLE, default 1, SHALL select round-robin grant (1) or fixed priority with requester 0 highest (0).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-006 req0_op1, req0_op2 / req1_op1, req1_op2  input  32  operands for requester N.
REQ-007 req0_operation / req1_operation  input  4  ALU code {funct7[5], funct3}.
REQ-008 resp_valid  output  1  result register holds an unconsumed result.
REQ-009 resp_ready  input  1  consumer accepts the result this cycle.
REQ-010 resp_id  output  1  requester index that issued the held result.
REQ-011 resp_result  output  32  ALU result for the held operation.
REQ-012 resp_illegal  output  1  held operation code was not a legal RV32I ALU code.

Function
REQ-013 Block SHALL share one ALU between two requesters with valid/ready handshakes on both sides.
REQ-014 A request transfers when reqN_valid and reqN_ready are both high at a rising clk edge.
REQ-015 Slot is free when resp_valid is low, or resp_valid and resp_ready are both high in the same cycle.
REQ-016 At most one of req0_ready/req1_ready SHALL be high per cycle; both low when slot not free.
REQ-017 reqN_ready SHALL be high only when reqN_valid is high, slot is free, and N wins arbitration.
REQ-018 Only one valid requester: it wins.
REQ-019 Both valid, RR_ENABLE=1: requester other than last_grant wins; RR_ENABLE=0: requester 0 wins.
REQ-020 last_grant SHALL update to the winner on each accepted request only.
REQ-021 Accepted operands/code SHALL be registered; ALU evaluates the registered values.
REQ-022 Latency: resp_valid high on the cycle after acceptance; with resp_ready held high, throughput is one operation per cycle.
REQ-023 Legal codes: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
REQ-024 Shift operations SHALL use only op2[4:0] as shift amount.
REQ-025 Illegal code: resp_result SHALL be 0 and resp_illegal 1; otherwise resp_illegal 0.
REQ-026 While resp_valid high and resp_ready low, resp_result, resp_id, resp_illegal SHALL hold stable.
REQ-027 resp_valid SHALL fall after a consume cycle unless a new request is accepted in that same cycle.
REQ-028 ADD/SUB SHALL wrap modulo 2^32; no overflow flag.
REQ-029 Requester dropping valid before acceptance is permitted; no operation is recorded.

Reset
REQ-030 rst_n low at a clk edge SHALL clear resp_valid, resp_id, resp_illegal, resp_result to 0 and set last_grant to 1.
REQ-031 During reset cycles req0_ready and req1_ready SHALL be 0.
REQ-032 Reset mid-operation SHALL discard the held result without a handshake; first request after reset from both requesters goes to requester 0.

Structure
REQ-033 Package alu_pkg SHALL hold the 4-bit operation code constants/enum and the legal-code check function.
REQ-034 The combinational ALU SHALL be a single sub-module instance named alu (operand1, operand2, operation, result); arbitration, slot register and illegal masking live in alu_arbiter.

Verification
REQ-035 Req0 only, ADD 5+7, resp_ready=1 -> next cycle resp_valid=1, resp_id=0, result 12, illegal 0.
REQ-036 Both valid every cycle after reset, RR_ENABLE=1, resp_ready=1 -> grants 0,1,0,1; results stream back-to-back with matching resp_id.
REQ-037 SRA 0x80000000 by op2=0x00000024 -> result 0xF8000000 (shift 4); SLT -1 vs 1 -> 1; SLTU 0xFFFFFFFF vs 1 -> 0.
REQ-038 resp_ready held 0 for 3 cycles with req1 valid -> req ready both 0, result stable; resp_ready=1 cycle -> req1 accepted same cycle, new result next cycle.
REQ-039 Code 1001 from req1 -> resp_result 0, resp_illegal 1, resp_id 1.
REQ-040 rst_n low while resp_valid=1 and resp_ready=0 -> resp_valid 0 next cycle; both valid afterwards -> req0 granted first.
